// File: rtl/vga_pkg.sv
// Shared VGA constants: colours, default display geometry, scale encoding and
// the per-axis bounce state.
package vga_pkg;

   localparam logic [23:0] BLACK = 24'h000000;
   localparam logic [23:0] WHITE = 24'hFFFFFF;
   localparam logic [23:0] RED   = 24'hFF0000;
   localparam logic [23:0] GREEN = 24'h00FF00;
   localparam logic [23:0] BLUE  = 24'h0000FF;

   localparam int unsigned DEF_H_DISP = 1280;
   localparam int unsigned DEF_V_DISP = 1024;

   typedef enum logic [1:0] {
      Scale1x    = 2'd0,
      Scale2x    = 2'd1,
      Scale4x    = 2'd2,
      Scale1xAlt = 2'd3
   } scale_e;

   typedef enum logic {
      DirPos = 1'b0,
      DirNeg = 1'b1
   } dir_e;

   typedef struct packed {
      logic [10:0] pos;
      dir_e        dir;
   } axis_t;

   function automatic logic [1:0] scale_shift(input logic [1:0] sel);
      logic [1:0] sh;
      case (sel)
         Scale2x: sh = 2'd1;
         Scale4x: sh = 2'd2;
         default: sh = 2'd0;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/vga_sprite_mover.sv
// Frame-boundary sprite state: position, bounce direction and scale shift, all
// updated only on the end-of-frame pixel so the sprite never tears.
module vga_sprite_mover
   import vga_pkg::*;
#(
   parameter int unsigned H_DISP = DEF_H_DISP,
   parameter int unsigned V_DISP = DEF_V_DISP,
   parameter int unsigned IMG_W  = 100,
   parameter int unsigned IMG_H  = 100,
   parameter int unsigned INIT_X = 590,
   parameter int unsigned INIT_Y = 462,
   parameter int unsigned STEP   = 2
) (
   input  logic        vga_clk,
   input  logic        sys_rst,
   input  logic        eof,
   input  logic [10:0] pos_x,
   input  logic [10:0] pos_y,
   input  logic [1:0]  scale_sel,
   input  logic        move_en,
   output logic [10:0] sprite_x,
   output logic [10:0] sprite_y,
   output logic [1:0]  sh
);

   localparam logic [11:0] HD = 12'(H_DISP);
   localparam logic [11:0] VD = 12'(V_DISP);
   localparam logic [11:0] IW = 12'(IMG_W);
   localparam logic [11:0] IH = 12'(IMG_H);
   localparam logic [11:0] ST = 12'(STEP);

   logic [10:0] x_q, y_q;
   dir_e        dir_x_q, dir_y_q;
   logic [1:0]  sh_q;

   logic [1:0]  sh_d;
   logic [11:0] span_w, span_h;
   axis_t       nx, ny;

   // Current position is clamped to the new span first, so a scale change
   // never leaves the sprite hanging off the screen edge.
   function automatic axis_t next_axis(input logic [11:0] cur, input logic [11:0] req,
                                       input logic [11:0] span, input logic [11:0] disp,
                                       input logic move, input dir_e dir);
      logic [11:0] lim;
      logic [11:0] c;
      logic [11:0] p;
      dir_e        d;
      lim = disp - span;
      c   = (cur > lim) ? lim : cur;
      d   = dir;
      p   = c;
      if (!move) begin
         p = (req > lim) ? lim : req;
      end else if (dir == DirPos) begin
         if (c + ST + span >= disp) begin
            p = lim;
            d = DirNeg;
         end else begin
            p = c + ST;
         end
      end else begin
         if (c < ST) begin
            p = 12'd0;
            d = DirPos;
         end else begin
            p = c - ST;
         end
      end
      return '{pos: p[10:0], dir: d};
   endfunction

   always_comb begin
      sh_d   = scale_shift(scale_sel);
      span_w = IW << sh_d;
      span_h = IH << sh_d;
      nx     = next_axis({1'b0, x_q}, {1'b0, pos_x}, span_w, HD, move_en, dir_x_q);
      ny     = next_axis({1'b0, y_q}, {1'b0, pos_y}, span_h, VD, move_en, dir_y_q);
   end

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         x_q     <= 11'(INIT_X);
         y_q     <= 11'(INIT_Y);
         dir_x_q <= DirPos;
         dir_y_q <= DirPos;
         sh_q    <= 2'd0;
      end else if (eof) begin
         x_q     <= nx.pos;
         y_q     <= ny.pos;
         dir_x_q <= nx.dir;
         dir_y_q <= ny.dir;
         sh_q    <= sh_d;
      end
   end

   assign sprite_x = x_q;
   assign sprite_y = y_q;
   assign sh       = sh_q;

endmodule

// File: rtl/vga_sprite_engine.sv
// Sprite overlay stage: maps pixel coordinates to image-ROM addresses and
// merges ROM data over the background, aligned to the ROM read latency.
module vga_sprite_engine
   import vga_pkg::*;
#(
   parameter int unsigned H_DISP    = DEF_H_DISP,
   parameter int unsigned V_DISP    = DEF_V_DISP,
   parameter int unsigned IMG_W     = 100,
   parameter int unsigned IMG_H     = 100,
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned ROM_LAT   = 1,
   parameter int unsigned INIT_X    = 590,
   parameter int unsigned INIT_Y    = 462,
   parameter int unsigned STEP      = 2,
   parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
   input  logic              vga_clk,
   input  logic              sys_rst,
   input  logic [10:0]       pixel_xpos,
   input  logic [10:0]       pixel_ypos,
   input  logic [10:0]       pos_x,
   input  logic [10:0]       pos_y,
   input  logic [1:0]        scale_sel,
   input  logic              move_en,
   input  logic              key_en,
   input  logic [23:0]       bg_color,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rd_en,
   input  logic [23:0]       rom_data,
   output logic [23:0]       pixel_data,
   output logic [10:0]       sprite_x,
   output logic [10:0]       sprite_y
);

   localparam int LAT = int'(ROM_LAT);

   logic              eof;
   logic [1:0]        sh;
   logic [11:0]       x12, y12, sx12, sy12;
   logic [11:0]       span_w, span_h;
   logic [11:0]       dx, dy;
   logic              hit;
   logic [ADDR_W-1:0] rom_offset;
   logic              show_rom;

   // Hit flag and background travel alongside the ROM access.
   logic              hit_pipe_q [0:LAT];
   logic [23:0]       bg_pipe_q  [0:LAT];

   assign eof = (pixel_xpos == 11'(H_DISP - 1)) && (pixel_ypos == 11'(V_DISP - 1));

   vga_sprite_mover #(
      .H_DISP (H_DISP),
      .V_DISP (V_DISP),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .INIT_X (INIT_X),
      .INIT_Y (INIT_Y),
      .STEP   (STEP)
   ) u_mover (
      .vga_clk   (vga_clk),
      .sys_rst   (sys_rst),
      .eof       (eof),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .scale_sel (scale_sel),
      .move_en   (move_en),
      .sprite_x  (sprite_x),
      .sprite_y  (sprite_y),
      .sh        (sh)
   );

   always_comb begin
      x12        = {1'b0, pixel_xpos};
      y12        = {1'b0, pixel_ypos};
      sx12       = {1'b0, sprite_x};
      sy12       = {1'b0, sprite_y};
      span_w     = 12'(IMG_W) << sh;
      span_h     = 12'(IMG_H) << sh;
      hit        = (x12 >= sx12) && (x12 < sx12 + span_w) &&
                   (y12 >= sy12) && (y12 < sy12 + span_h);
      dx         = (x12 - sx12) >> sh;
      dy         = (y12 - sy12) >> sh;
      rom_offset = ADDR_W'(dy) * ADDR_W'(IMG_W) + ADDR_W'(dx);
   end

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         rom_addr  <= '0;
         rom_rd_en <= 1'b0;
      end else begin
         rom_rd_en <= hit;
         if (hit) begin
            rom_addr <= rom_offset;
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         for (int i = 0; i <= LAT; i++) begin
            hit_pipe_q[i] <= 1'b0;
            bg_pipe_q[i]  <= '0;
         end
      end else begin
         hit_pipe_q[0] <= hit;
         bg_pipe_q[0]  <= bg_color;
         for (int i = 1; i <= LAT; i++) begin
            hit_pipe_q[i] <= hit_pipe_q[i-1];
            bg_pipe_q[i]  <= bg_pipe_q[i-1];
         end
      end
   end

   assign show_rom = hit_pipe_q[LAT] && !(key_en && (rom_data == KEY_COLOR));

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         pixel_data <= '0;
      end else begin
         pixel_data <= show_rom ? rom_data : bg_pipe_q[LAT];
      end
   end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Self-checking bench for vga_sprite_engine: vector table with a timed
// scoreboard, plus directed sequences for EOF updates, bounce and reset.
module tb_vga_sprite_engine;

   localparam int ROM_LAT = 1;
   localparam logic [23:0] KEY = 24'hFF00FF;

   logic        vga_clk = 1'b0;
   logic        sys_rst;
   logic [10:0] pixel_xpos, pixel_ypos, pos_x, pos_y;
   logic [1:0]  scale_sel;
   logic        move_en, key_en;
   logic [23:0] bg_color;
   logic [13:0] rom_addr;
   logic        rom_rd_en;
   logic [23:0] rom_data;
   logic [23:0] pixel_data;
   logic [10:0] sprite_x, sprite_y;

   vga_sprite_engine #(.ROM_LAT(ROM_LAT)) dut (
      .vga_clk    (vga_clk),
      .sys_rst    (sys_rst),
      .pixel_xpos (pixel_xpos),
      .pixel_ypos (pixel_ypos),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .scale_sel  (scale_sel),
      .move_en    (move_en),
      .key_en     (key_en),
      .bg_color   (bg_color),
      .rom_addr   (rom_addr),
      .rom_rd_en  (rom_rd_en),
      .rom_data   (rom_data),
      .pixel_data (pixel_data),
      .sprite_x   (sprite_x),
      .sprite_y   (sprite_y)
   );

   always #5 vga_clk = ~vga_clk;

   int cyc = 0;
   always @(posedge vga_clk) cyc <= cyc + 1;

   function automatic logic [23:0] rom_fn(input logic [13:0] a);
      return (a == 14'd5) ? KEY : {10'h040, a};
   endfunction

   // One-cycle ROM
   always @(posedge vga_clk) rom_data <= rom_fn(rom_addr);

   typedef struct {
      int x;
      int y;
      bit hit;
      int addr;
   } vec_t;

   typedef struct {
      int          due;
      bit          is_pix;
      bit          hit;
      logic [23:0] exp;
      string       name;
   } exp_t;

   vec_t tbl[22];
   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   always @(negedge vga_clk) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].due == cyc) begin
            exp_t e;
            e = exp_q[i];
            if (e.is_pix) begin
               chk({e.name, ".pix"}, {8'h0, pixel_data}, {8'h0, e.exp});
            end else if (e.hit) begin
               chk({e.name, ".rd_en"}, {31'h0, rom_rd_en}, 32'd1);
               chk({e.name, ".addr"}, {18'h0, rom_addr}, {8'h0, e.exp});
            end else begin
               chk({e.name, ".rd_en"}, {31'h0, rom_rd_en}, 32'd0);
            end
            exp_q.delete(i);
         end
      end
   end

   task automatic drive(input int x, input int y);
      pixel_xpos = 11'(x);
      pixel_ypos = 11'(y);
   endtask

   // Call right after driving a coordinate at a negedge.
   task automatic expect_vec(input string name, input bit hit, input int addr);
      logic [23:0] w, pix;
      w   = rom_fn(14'(addr));
      pix = !hit ? bg_color : ((key_en && w == KEY) ? bg_color : w);
      exp_q.push_back('{due: cyc + 1, is_pix: 1'b0, hit: hit, exp: 24'(addr), name: name});
      exp_q.push_back('{due: cyc + 2 + ROM_LAT, is_pix: 1'b1, hit: hit, exp: pix, name: name});
   endtask

   task automatic drain();
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge vga_clk);
      if (exp_q.size() > 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic apply(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         @(negedge vga_clk);
         drive(tbl[i].x, tbl[i].y);
         expect_vec($sformatf("vec%0d", i), tbl[i].hit, tbl[i].addr);
      end
      @(negedge vga_clk);
      drive(0, 0);
      drain();
   endtask

   task automatic eof_pulse();
      @(negedge vga_clk);
      drive(1279, 1023);
      @(negedge vga_clk);
      drive(0, 0);
   endtask

   task automatic chk_pos(input string name, input int ex, input int ey);
      chk({name, ".sx"}, {21'h0, sprite_x}, 32'(ex));
      chk({name, ".sy"}, {21'h0, sprite_y}, 32'(ey));
   endtask

   initial begin
      // 1x at (590,462)
      tbl[0]  = '{590, 462, 1, 0};
      tbl[1]  = '{689, 561, 1, 9999};
      tbl[2]  = '{690, 462, 0, 0};
      tbl[3]  = '{595, 462, 1, 5};
      tbl[4]  = '{600, 470, 1, 810};
      tbl[5]  = '{589, 462, 0, 0};
      tbl[6]  = '{590, 562, 0, 0};
      // colour key
      tbl[7]  = '{595, 462, 1, 5};
      tbl[8]  = '{596, 462, 1, 6};
      // 2x at (590,462)
      tbl[9]  = '{590, 462, 1, 0};
      tbl[10] = '{591, 462, 1, 0};
      tbl[11] = '{590, 463, 1, 0};
      tbl[12] = '{591, 463, 1, 0};
      tbl[13] = '{592, 464, 1, 101};
      tbl[14] = '{789, 661, 1, 9999};
      tbl[15] = '{790, 661, 0, 0};
      tbl[16] = '{789, 662, 0, 0};
      // 4x clamped to (880,624)
      tbl[17] = '{880, 624, 1, 0};
      tbl[18] = '{883, 627, 1, 0};
      tbl[19] = '{884, 628, 1, 101};
      tbl[20] = '{879, 624, 0, 0};
      tbl[21] = '{1279, 1022, 1, 9999};

      sys_rst   = 1'b1;
      drive(0, 0);
      pos_x     = 11'd590;
      pos_y     = 11'd462;
      scale_sel = 2'd0;
      move_en   = 1'b0;
      key_en    = 1'b0;
      bg_color  = 24'h123456;
      repeat (3) @(negedge vga_clk);
      chk("rst.addr", {18'h0, rom_addr}, 32'd0);
      chk("rst.rd_en", {31'h0, rom_rd_en}, 32'd0);
      chk("rst.pix", {8'h0, pixel_data}, 32'd0);
      chk_pos("rst", 590, 462);
      sys_rst = 1'b0;

      apply(0, 6);

      key_en   = 1'b1;
      bg_color = 24'h0000FF;
      apply(7, 8);
      key_en   = 1'b0;
      bg_color = 24'h123456;

      scale_sel = 2'd1;
      eof_pulse();
      chk_pos("scale2", 590, 462);
      apply(9, 16);

      scale_sel = 2'd2;
      pos_x     = 11'd1250;
      pos_y     = 11'd1000;
      eof_pulse();
      chk_pos("scale4.clamp", 880, 624);
      apply(17, 21);

      scale_sel = 2'd0;
      eof_pulse();
      chk_pos("scale1.clamp", 1180, 924);
      pos_x = 11'd300;
      repeat (5) @(negedge vga_clk);
      chk_pos("midframe.hold", 1180, 924);
      eof_pulse();
      chk_pos("midframe.apply", 300, 924);

      pos_x = 11'd1176;
      pos_y = 11'd462;
      eof_pulse();
      chk_pos("bounce.start", 1176, 462);
      move_en = 1'b1;
      eof_pulse();
      chk_pos("bounce.1", 1178, 464);
      eof_pulse();
      chk_pos("bounce.2", 1180, 466);
      eof_pulse();
      chk_pos("bounce.3", 1178, 468);
      move_en = 1'b0;
      pos_x   = 11'd1;
      eof_pulse();
      chk_pos("bounce.park", 1, 462);
      move_en = 1'b1;
      eof_pulse();
      chk_pos("bounce.left", 0, 464);
      eof_pulse();
      chk_pos("bounce.flip", 2, 466);

      move_en = 1'b0;
      pos_x   = 11'd100;
      pos_y   = 11'd200;
      eof_pulse();
      chk_pos("prerst", 100, 200);
      @(negedge vga_clk);
      drive(110, 210);
      @(negedge vga_clk);
      drive(111, 210);
      @(negedge vga_clk);
      sys_rst = 1'b1;
      drive(600, 470);
      @(negedge vga_clk);
      chk("rst2.rd_en", {31'h0, rom_rd_en}, 32'd0);
      chk("rst2.pix", {8'h0, pixel_data}, 32'd0);
      chk_pos("rst2", 590, 462);
      sys_rst = 1'b0;
      drive(600, 470);
      for (int k = 1; k <= ROM_LAT + 1; k++) begin
         exp_q.push_back('{due: cyc + k, is_pix: 1'b1, hit: 1'b0, exp: 24'h0,
                           name: $sformatf("rst2.zero%0d", k)});
      end
      expect_vec("rst2.v0", 1'b1, 810);
      @(negedge vga_clk);
      drive(601, 470);
      expect_vec("rst2.v1", 1'b1, 811);
      @(negedge vga_clk);
      drive(0, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
